// File: rtl/store_queue.sv
// store_queue: in-order store buffer between the store execution unit and memory.
// Entries sit in a circular FIFO indexed by three pointers, each one bit wider
// than the index:
//   head  oldest entry (the next write to memory)
//   cmt   first uncommitted entry
//   tail  next free slot
// Slots in [head,cmt) are committed and drain to memory one per cycle.
// Slots in [cmt,tail) are pending until the ROB commits them, or until a flush
// discards them.
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   store_*                   enqueue request: address, data, funct3, ROB tag
//   commit_valid/commit_rob_id  ROB commit event
//   flush                     drop all pending (uncommitted) stores
//   mem_we/waddr/wdata/wstrb  write request for the head entry
//   mem_ready                 memory accepts the write this cycle
//   load_addr/load_conflict   word-granular overlap probe for loads
//   sq_full/sq_empty/sq_count occupancy, derived from registered pointers
module store_queue #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 5,
  parameter int DEPTH      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      store_valid,
  input  logic [ADDR_WIDTH-1:0]     store_waddr,
  input  logic [DATA_WIDTH-1:0]     store_wdata,
  input  logic [2:0]                store_funct3,
  input  logic [ROB_WIDTH-1:0]      store_rob_id,
  input  logic                      commit_valid,
  input  logic [ROB_WIDTH-1:0]      commit_rob_id,
  input  logic                      flush,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_waddr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  output logic [DATA_WIDTH/8-1:0]   mem_wstrb,
  input  logic                      mem_ready,
  input  logic [ADDR_WIDTH-1:0]     load_addr,
  output logic                      load_conflict,
  output logic                      sq_full,
  output logic                      sq_empty,
  output logic [$clog2(DEPTH):0]    sq_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int SW = DATA_WIDTH / 8;

  // Entry payload; not reset, validity comes from the pointers alone.
  logic [ADDR_WIDTH-1:0] e_addr [DEPTH];
  logic [DATA_WIDTH-1:0] e_data [DEPTH];
  logic [SW-1:0]         e_strb [DEPTH];
  logic [ROB_WIDTH-1:0]  e_rob  [DEPTH];

  logic [PW-1:0] head, cmt, tail;
  logic [PW-1:0] cmt_next, tail_next, count;
  logic [IW-1:0] head_idx, cmt_idx, tail_idx, offs;
  logic [3:0]    strb4;
  logic [SW-1:0] strb_in;
  logic          has_committed, drain, enq, commit_ok;

  assign head_idx = head[IW-1:0];
  assign cmt_idx  = cmt[IW-1:0];
  assign tail_idx = tail[IW-1:0];

  assign count    = tail - head;
  assign sq_count = count;
  assign sq_full  = (count == PW'(DEPTH));
  assign sq_empty = (count == '0);

  always_comb begin
    strb4 = '0;
    case (store_funct3)
      3'b000:  strb4 = 4'b0001 << store_waddr[1:0];
      3'b001:  strb4 = store_waddr[1] ? 4'b1100 : 4'b0011;
      3'b010:  strb4 = 4'b1111;
      default: strb4 = '0;
    endcase
    strb_in = SW'(strb4);
  end

  assign has_committed = (head != cmt);
  assign drain         = has_committed && mem_ready;
  // Full is judged on the registered count, so a same-cycle drain cannot make room.
  assign enq           = store_valid && !sq_full && !flush;
  // Commit compares against pre-edge contents; an entry enqueued this cycle is not visible.
  assign commit_ok     = commit_valid && (cmt != tail) && (commit_rob_id == e_rob[cmt_idx]);

  // Flush truncates to the post-commit cmt so a same-cycle commit survives.
  assign cmt_next  = cmt + PW'(commit_ok);
  assign tail_next = flush ? cmt_next : tail + PW'(enq);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + PW'(drain);
      cmt  <= cmt_next;
      tail <= tail_next;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      e_addr[tail_idx] <= store_waddr;
      e_data[tail_idx] <= store_wdata;
      e_strb[tail_idx] <= strb_in;
      e_rob[tail_idx]  <= store_rob_id;
    end
  end

  always_comb begin
    mem_we    = has_committed;
    mem_waddr = '0;
    mem_wdata = '0;
    mem_wstrb = '0;
    if (has_committed) begin
      mem_waddr = e_addr[head_idx];
      mem_wdata = e_data[head_idx];
      mem_wstrb = e_strb[head_idx];
    end
  end

  // A slot is live when its distance from head (mod DEPTH) is below the occupancy.
  always_comb begin
    load_conflict = 1'b0;
    offs          = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offs = IW'(i) - head_idx;
      if ((PW'(offs) < count) &&
          (e_addr[i][ADDR_WIDTH-1:2] == load_addr[ADDR_WIDTH-1:2]))
        load_conflict = 1'b1;
    end
  end

endmodule

// File: tb/tb_store_queue.sv
module tb_store_queue;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int D  = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          store_valid;
  logic [AW-1:0] store_waddr;
  logic [DW-1:0] store_wdata;
  logic [2:0]    store_funct3;
  logic [RW-1:0] store_rob_id;
  logic          commit_valid;
  logic [RW-1:0] commit_rob_id;
  logic          flush;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_ready;
  logic [AW-1:0] load_addr;
  logic          load_conflict;
  logic          sq_full;
  logic          sq_empty;
  logic [3:0]    sq_count;

  int n_vec = 0;
  int n_err = 0;

  store_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ROB_WIDTH(RW), .DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .store_valid(store_valid), .store_waddr(store_waddr), .store_wdata(store_wdata),
    .store_funct3(store_funct3), .store_rob_id(store_rob_id),
    .commit_valid(commit_valid), .commit_rob_id(commit_rob_id), .flush(flush),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .load_addr(load_addr), .load_conflict(load_conflict),
    .sq_full(sq_full), .sq_empty(sq_empty), .sq_count(sq_count)
  );

  always #5 clk = ~clk;

  // Reference model: program-ordered list of stores; the first nc are committed.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    s;
    logic [RW-1:0] r;
  } ent_t;
  ent_t q[$];
  int   nc = 0;

  function automatic logic [3:0] strb_of(logic [2:0] f, logic [AW-1:0] a);
    case (f)
      3'b000:  return 4'b0001 << a[1:0];
      3'b001:  return a[1] ? 4'b1100 : 4'b0011;
      3'b010:  return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic          we, cf;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [3:0]    es;
    we = (nc > 0);
    ea = '0; ed = '0; es = '0;
    if (we) begin
      ea = q[0].a; ed = q[0].d; es = q[0].s;
    end
    cf = 1'b0;
    foreach (q[i]) if (q[i].a[AW-1:2] == load_addr[AW-1:2]) cf = 1'b1;
    check("mem_we",        64'(mem_we),        64'(we));
    check("mem_waddr",     64'(mem_waddr),     64'(ea));
    check("mem_wdata",     64'(mem_wdata),     64'(ed));
    check("mem_wstrb",     64'(mem_wstrb),     64'(es));
    check("load_conflict", 64'(load_conflict), 64'(cf));
    check("sq_count",      64'(sq_count),      64'(q.size()));
    check("sq_full",       64'(sq_full),       64'(q.size() == D));
    check("sq_empty",      64'(sq_empty),      64'(q.size() == 0));
  endtask

  // Check outputs against the model, advance the model with the current inputs,
  // then let the clock edge happen.
  task automatic step();
    bit   full, drain, cmt_ok, enq;
    ent_t e;
    #1;
    check_outputs();
    full   = (q.size() == D);
    drain  = (nc > 0) && mem_ready;
    cmt_ok = commit_valid && (nc < q.size()) && (q[nc].r == commit_rob_id);
    enq    = store_valid && !full && !flush;
    if (cmt_ok) nc++;
    if (flush) begin
      while (q.size() > nc) void'(q.pop_back());
    end else if (enq) begin
      e.a = store_waddr; e.d = store_wdata; e.s = strb_of(store_funct3, store_waddr); e.r = store_rob_id;
      q.push_back(e);
    end
    if (drain) begin
      void'(q.pop_front());
      nc--;
    end
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    store_valid = 1'b0; commit_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic put(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] f,
                     input logic [RW-1:0] r);
    idle();
    store_valid = 1'b1; store_waddr = a; store_wdata = d; store_funct3 = f; store_rob_id = r;
    step();
    idle();
  endtask

  task automatic commit(input logic [RW-1:0] r);
    idle();
    commit_valid = 1'b1; commit_rob_id = r;
    step();
    idle();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_mem_we",   64'(mem_we),        64'(0));
    check("rst_count",    64'(sq_count),      64'(0));
    check("rst_empty",    64'(sq_empty),      64'(1));
    check("rst_conflict", 64'(load_conflict), 64'(0));
    q.delete();
    nc = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    store_waddr = '0; store_wdata = '0; store_funct3 = '0; store_rob_id = '0;
    commit_rob_id = '0; load_addr = 32'h0000_0FFC;
    do_reset();

    // SW commit and single-cycle drain
    put(32'h100, 32'hDEADBEEF, 3'b010, 5'd3);
    commit(5'd3);
    check("sw_we",    64'(mem_we),    64'(1));
    check("sw_addr",  64'(mem_waddr), 64'(32'h100));
    check("sw_data",  64'(mem_wdata), 64'(32'hDEADBEEF));
    check("sw_strb",  64'(mem_wstrb), 64'(4'b1111));
    mem_ready = 1'b1; step(); idle();
    check("sw_empty", 64'(sq_empty),  64'(1));

    // SB then SH, first write held while mem_ready is low
    put(32'h203, 32'hAA00_0000, 3'b000, 5'd4);
    put(32'h206, 32'hBBBB_0000, 3'b001, 5'd5);
    commit(5'd4);
    commit(5'd5);
    for (int i = 0; i < 3; i++) begin
      check("sb_hold_strb", 64'(mem_wstrb), 64'(4'b1000));
      check("sb_hold_addr", 64'(mem_waddr), 64'(32'h203));
      step();
    end
    mem_ready = 1'b1; step();
    check("sh_strb", 64'(mem_wstrb), 64'(4'b1100));
    step(); idle();
    check("sbsh_empty", 64'(sq_empty), 64'(1));

    // Fill, reject the ninth store, drain+enqueue while full
    for (int i = 0; i < D; i++) put(32'h300 + 32'(4 * i), 32'(i), 3'b010, 5'(i));
    check("full_flag",  64'(sq_full),  64'(1));
    check("full_count", 64'(sq_count), 64'(8));
    put(32'h500, 32'h9, 3'b010, 5'd9);
    check("ninth_count", 64'(sq_count), 64'(8));
    commit(5'd0);
    store_valid = 1'b1; store_waddr = 32'h600; store_rob_id = 5'd10; mem_ready = 1'b1;
    step(); idle();
    check("drain_enq_count", 64'(sq_count), 64'(7));
    flush = 1'b1; step(); idle();

    // Flush together with a commit keeps the just-committed store
    put(32'h10, 32'h1, 3'b010, 5'd1);
    put(32'h20, 32'h2, 3'b010, 5'd2);
    put(32'h30, 32'h3, 3'b010, 5'd3);
    commit(5'd1);
    commit_valid = 1'b1; commit_rob_id = 5'd2; flush = 1'b1;
    step(); idle();
    check("flush_count", 64'(sq_count), 64'(2));
    mem_ready = 1'b1;
    check("flush_w1", 64'(mem_waddr), 64'(32'h10));
    step();
    check("flush_w2", 64'(mem_waddr), 64'(32'h20));
    step(); idle();
    check("flush_empty", 64'(sq_empty), 64'(1));
    check("flush_we",    64'(mem_we),   64'(0));

    // Load conflict probing at word granularity
    put(32'h40, 32'h40, 3'b010, 5'd7);
    load_addr = 32'h42; #1;
    check("ld_conf_hit",  64'(load_conflict), 64'(1));
    load_addr = 32'h44; #1;
    check("ld_conf_miss", 64'(load_conflict), 64'(0));
    commit(5'd7);
    mem_ready = 1'b1; step(); idle();
    load_addr = 32'h42; #1;
    check("ld_conf_drained", 64'(load_conflict), 64'(0));

    // Asynchronous reset during a stalled drain
    put(32'h80, 32'h8, 3'b010, 5'd8);
    commit(5'd8);
    check("pre_rst_we", 64'(mem_we), 64'(1));
    do_reset();
    step();
    check("post_rst_count", 64'(sq_count), 64'(0));

    // Randomized traffic over a small address window
    for (int c = 0; c < 3000; c++) begin
      store_valid  = ($urandom_range(0, 99) < 55);
      store_waddr  = 32'h1000 + 32'($urandom_range(0, 31));
      store_wdata  = $urandom;
      store_funct3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      store_rob_id = RW'($urandom);
      commit_valid = ($urandom_range(0, 99) < 50);
      if ((nc < q.size()) && ($urandom_range(0, 3) != 0)) commit_rob_id = q[nc].r;
      else commit_rob_id = RW'($urandom);
      flush        = ($urandom_range(0, 99) < 4);
      mem_ready    = ($urandom_range(0, 99) < 60);
      load_addr    = 32'h1000 + 32'($urandom_range(0, 35));
      step();
    end
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/store_queue.md
STORE_QUEUE -- requirements
Module: store_queue

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: store/memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: store data width, with DATA_WIDTH/8 byte strobes.
REQ-003 SHALL have parameter ROB_WIDTH, default 5: ROB tag width.
REQ-004 SHALL have parameter DEPTH, default 8: entry count, power of two.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-007 SHALL have port store_valid, input, 1: enqueue request from the store execution unit.
REQ-008 SHALL have port store_waddr, input, ADDR_WIDTH: byte address of the store.
REQ-009 SHALL have port store_wdata, input, DATA_WIDTH: store data, already placed in its byte lanes.
REQ-010 SHALL have port store_funct3, input, 3: SB=000, SH=001, SW=010.
REQ-011 SHALL have port store_rob_id, input, ROB_WIDTH: ROB tag of the store.
REQ-012 SHALL have port commit_valid, input, 1: ROB commit event.
REQ-013 SHALL have port commit_rob_id, input, ROB_WIDTH: tag of the committing instruction.
REQ-014 SHALL have port flush, input, 1: discard all uncommitted stores.
REQ-015 SHALL have port mem_we, output, 1: memory write request.
REQ-016 SHALL have port mem_waddr, output, ADDR_WIDTH: write address.
REQ-017 SHALL have port mem_wdata, output, DATA_WIDTH: write data.
REQ-018 SHALL have port mem_wstrb, output, DATA_WIDTH/8: byte enables.
REQ-019 SHALL have port mem_ready, input, 1: memory accepts the write this cycle.
REQ-020 SHALL have port load_addr, input, ADDR_WIDTH: address of a load probing for a conflict.
REQ-021 SHALL have port load_conflict, output, 1: a queued store overlaps the load's word.
REQ-022 SHALL have port sq_full, output, 1: queue is full.
REQ-023 SHALL have port sq_empty, output, 1: queue is empty.
REQ-024 SHALL have port sq_count, output, $clog2(DEPTH)+1: current occupancy.

Function
REQ-025 SHALL keep entries in a circular FIFO in program order using three pointers, each one bit wider than the index:
- head: oldest entry.
- cmt: first uncommitted entry.
- tail: next free slot.
- Ordering is head <= cmt <= tail modulo wrap.
REQ-026 SHALL classify entries by position: [head,cmt) is COMMITTED, [cmt,tail) is PENDING, and every other slot is INVALID.
REQ-027 SHALL, when store_valid && !sq_full, write {waddr, wdata, wstrb, rob_id} at tail and advance tail by one; when store_valid && sq_full, the request SHALL be ignored with no state change.
REQ-028 SHALL compute wstrb at enqueue as follows:
- SB: 4'b0001 << addr[1:0].
- SH: addr[1] ? 4'b1100 : 4'b0011.
- SW: 4'b1111.
- Any other funct3: 4'b0000, with the entry still enqueued.
REQ-029 SHALL, when commit_valid && cmt!=tail && commit_rob_id equals the rob_id of the entry at cmt, advance cmt by one; otherwise commit SHALL be ignored (non-store commit).
REQ-030 SHALL drive mem_we=1 whenever head!=cmt, with mem_waddr/mem_wdata/mem_wstrb taken from the entry at head and held stable until mem_ready.
REQ-031 SHALL, on mem_we && mem_ready, advance head by one (one write per cycle maximum).
REQ-032 SHALL drive mem_we=0 and mem_waddr/mem_wdata/mem_wstrb=0 when head==cmt.
REQ-033 SHALL, on flush, set tail <= next-cycle cmt, dropping all PENDING entries while COMMITTED entries keep draining.
REQ-034 SHALL resolve same-cycle flush with other events as follows:
- Flush with enqueue: flush wins and the enqueue is discarded.
- Flush with commit: the commit applies first, then the flush, so the just-committed entry survives.
REQ-035 SHALL evaluate same-cycle commit and enqueue of the same rob_id against pre-edge contents only, so that commit is ignored.
REQ-036 SHALL derive sq_full, sq_empty and sq_count from registered pointers only:
- sq_count = tail - head.
- sq_full = (count == DEPTH).
- sq_empty = (count == 0).
- A drain in the same cycle SHALL NOT unblock an enqueue while full.
REQ-037 SHALL drive load_conflict combinationally as 1 iff any entry in [head,tail) has waddr[ADDR_WIDTH-1:2] == load_addr[ADDR_WIDTH-1:2].
REQ-038 SHALL handle pointer wrap-around correctly, including DEPTH consecutive enqueues after the queue has drained across the index boundary.

Reset
REQ-039 SHALL, on rst asserted, immediately and asynchronously:
- Clear head, cmt and tail to 0.
- Drive mem_we=0, mem_waddr/mem_wdata/mem_wstrb=0, load_conflict=0.
- Drive sq_full=0, sq_empty=1, sq_count=0.
REQ-040 SHALL discard all entries, committed or not, on reset mid-operation, including a write in progress whose mem_ready has not yet arrived.
REQ-041 SHALL leave entry payload storage unreset; only the pointers are reset.

Verification
REQ-042 SHALL cover: enqueue SW addr=0x100 data=0xDEADBEEF rob=3 -> commit rob=3 -> mem_we=1, waddr=0x100, wdata=0xDEADBEEF, wstrb=1111 the next cycle; with mem_ready=1, sq_empty=1 the following cycle.
REQ-043 SHALL cover: enqueue SB addr=0x203 and SH addr=0x206, commit both -> wstrb 1000 then 1100 in order; mem_ready held 0 for 3 cycles keeps the first write stable.
REQ-044 SHALL cover: enqueue 8 stores -> sq_full=1, sq_count=8; a 9th store_valid is ignored; a drain plus enqueue in the same cycle leaves count=7.
REQ-045 SHALL cover: enqueue rob 1,2,3, commit rob 1, flush together with commit rob 2 -> rob 1 and 2 drain and rob 3 never reaches memory; sq_empty=1 after the drain.
REQ-046 SHALL cover: store at 0x40 pending, load_addr=0x42 -> load_conflict=1; load_addr=0x44 -> load_conflict=0; after drain, load_addr=0x42 -> load_conflict=0.
REQ-047 SHALL cover: rst asserted mid-drain with mem_ready=0 -> mem_we falls to 0 without a clock edge, and sq_count=0 after rst deasserts.
